// File: rtl/display_pkg.sv
// Shared types and constants for the display source scheduler.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_URGENT = 2'd2
    } state_t;

    localparam logic [7:0] BLANK_BYTE      = 8'h00;
    localparam int         DEFAULT_NUM_SRC = 4;

endpackage

// File: rtl/rr_next_valid.sv
// Round-robin search: first set bit of valid after cur, wrapping, cur itself last.
// With cur = NUM_SRC-1 this degenerates to a lowest-set-bit search.
module rr_next_valid
    import display_pkg::*;
#(
    parameter int NUM_SRC = DEFAULT_NUM_SRC
) (
    input  logic [NUM_SRC-1:0]         valid,
    input  logic [$clog2(NUM_SRC)-1:0] cur,
    output logic [$clog2(NUM_SRC)-1:0] nxt,
    output logic                       found
);

    localparam int IW = $clog2(NUM_SRC);

    logic [IW-1:0] idx;

    // Scan farthest-first so the nearest candidate is the last one written.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = IW'((int'(cur) + k) % NUM_SRC);
            if (valid[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_source_sched.sv
// Picks one byte-wide source at a time for the hex display: dwell rotation,
// manual advance and timed urgent override; all outputs registered.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | nothing valid, display blanked
// ST_SHOW   | showing src cur, dwell counter running when auto_en
// ST_URGENT | showing urgent winner cur until urgent timer expires
module display_source_sched
    import display_pkg::*;
#(
    parameter int NUM_SRC       = DEFAULT_NUM_SRC,
    parameter int DWELL_CYCLES  = 50_000_000,
    parameter int URGENT_CYCLES = 25_000_000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [8*NUM_SRC-1:0]         src_data,
    input  logic [NUM_SRC-1:0]           urgent,
    input  logic                         auto_en,
    input  logic                         next,
    output logic [7:0]                   disp_data,
    output logic [$clog2(NUM_SRC)-1:0]   disp_src,
    output logic                         disp_blank
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int UW = $clog2(URGENT_CYCLES);

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [UW-1:0] URG_LAST   = UW'(URGENT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_SRC - 1);

    state_t        state_q, state_n;
    logic [IW-1:0] cur_q, cur_n;
    logic [IW-1:0] saved_q, saved_n;
    logic          saved_vld_q, saved_vld_n;
    logic [DW-1:0] dwell_q, dwell_n;
    logic [UW-1:0] urg_q, urg_n;

    logic [IW-1:0] adv_idx, low_idx, urg_idx, sav_idx;
    logic          adv_found, low_found, urg_found, sav_found;
    logic [7:0]    src_byte [NUM_SRC];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_byte[i] = src_data[8*i +: 8];
        end
    end

    rr_next_valid #(.NUM_SRC(NUM_SRC)) u_adv (
        .valid(src_valid), .cur(cur_q),    .nxt(adv_idx), .found(adv_found)
    );
    rr_next_valid #(.NUM_SRC(NUM_SRC)) u_low (
        .valid(src_valid), .cur(LAST_IDX), .nxt(low_idx), .found(low_found)
    );
    rr_next_valid #(.NUM_SRC(NUM_SRC)) u_urg (
        .valid(urgent),    .cur(LAST_IDX), .nxt(urg_idx), .found(urg_found)
    );
    rr_next_valid #(.NUM_SRC(NUM_SRC)) u_sav (
        .valid(src_valid), .cur(saved_q),  .nxt(sav_idx), .found(sav_found)
    );

    always_comb begin
        state_n     = state_q;
        cur_n       = cur_q;
        saved_n     = saved_q;
        saved_vld_n = saved_vld_q;
        dwell_n     = dwell_q;
        urg_n       = urg_q;

        if (urg_found) begin
            state_n = ST_URGENT;
            cur_n   = urg_idx;
            urg_n   = '0;
            dwell_n = '0;
            // A re-trigger while already urgent keeps the original return point.
            if (state_q == ST_SHOW) begin
                saved_n     = cur_q;
                saved_vld_n = 1'b1;
            end else if (state_q == ST_IDLE) begin
                saved_vld_n = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (low_found) begin
                        state_n = ST_SHOW;
                        cur_n   = low_idx;
                        dwell_n = '0;
                    end
                end
                ST_SHOW: begin
                    if (next || (auto_en && dwell_q == DWELL_LAST) || !src_valid[cur_q]) begin
                        dwell_n = '0;
                        if (adv_found) begin
                            cur_n = adv_idx;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        dwell_n = auto_en ? dwell_q + 1'b1 : '0;
                    end
                end
                ST_URGENT: begin
                    if (urg_q == URG_LAST) begin
                        urg_n   = '0;
                        dwell_n = '0;
                        state_n = ST_SHOW;
                        if (saved_vld_q && src_valid[saved_q]) begin
                            cur_n = saved_q;
                        end else if (saved_vld_q && sav_found) begin
                            cur_n = sav_idx;
                        end else if (!saved_vld_q && low_found) begin
                            cur_n = low_idx;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        urg_n = urg_q + 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            saved_q     <= '0;
            saved_vld_q <= 1'b0;
            dwell_q     <= '0;
            urg_q       <= '0;
            disp_data   <= BLANK_BYTE;
            disp_src    <= '0;
            disp_blank  <= 1'b1;
        end else begin
            state_q     <= state_n;
            cur_q       <= cur_n;
            saved_q     <= saved_n;
            saved_vld_q <= saved_vld_n;
            dwell_q     <= dwell_n;
            urg_q       <= urg_n;
            disp_src    <= cur_n;
            disp_blank  <= (state_n == ST_IDLE);
            disp_data   <= (state_n == ST_IDLE) ? BLANK_BYTE : src_byte[cur_n];
        end
    end

endmodule

// File: tb/tb_display_source_sched.sv
// Directed bench for display_source_sched: the driver queues expected outputs
// per clock edge, a separate monitor pops and compares them.
module tb_display_source_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src_valid;
    logic [3:0] urgent;
    logic [31:0] src_data;
    logic       auto_en;
    logic       next_p;
    logic [7:0] disp_data;
    logic [1:0] disp_src;
    logic       disp_blank;
    logic [7:0] sd [4];

    assign src_data = {sd[3], sd[2], sd[1], sd[0]};

    display_source_sched #(
        .NUM_SRC(4), .DWELL_CYCLES(4), .URGENT_CYCLES(3)
    ) dut (
        .CLK(clk), .RST(rst),
        .src_valid(src_valid), .src_data(src_data), .urgent(urgent),
        .auto_en(auto_en), .next(next_p),
        .disp_data(disp_data), .disp_src(disp_src), .disp_blank(disp_blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] src;
        logic [7:0] data;
        logic       blank;
        bit         chk_src;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: outputs for edge N are stable at the following negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
                e = q.pop_front();
                n_cmp++;
                if (e.cyc != edge_cnt || disp_data !== e.data || disp_blank !== e.blank ||
                    (e.chk_src && disp_src !== e.src)) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got src=%0d data=%h blank=%b, want src=%0d data=%h blank=%b (for edge %0d)",
                             e.name, edge_cnt, disp_src, disp_data, disp_blank,
                             e.src, e.data, e.blank, e.cyc);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_show(input string nm, input int s);
        q.push_back('{edge_cnt + 1, nm, 2'(s), sd[s], 1'b0, 1'b1});
        cyc();
    endtask

    task automatic tick_blank(input string nm, input bit chk_src);
        q.push_back('{edge_cnt + 1, nm, 2'd0, 8'h00, 1'b1, chk_src});
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    int seq_rot [15] = '{0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3, 0, 0, 0, 0};

    initial begin
        rst = 1'b1; src_valid = 4'b0000; urgent = 4'b0000;
        auto_en = 1'b0; next_p = 1'b0;
        sd[0] = 8'h3C; sd[1] = 8'hA1; sd[2] = 8'hB2; sd[3] = 8'hC3;

        tick_blank("reset", 1'b1);
        tick_blank("reset", 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick_blank("idle_blank", 1'b1);
        src_valid = 4'b0101;
        tick_show("idle_to_show", 0);

        // Auto rotation over 0,1,3 with a live data change on source 1.
        auto_en = 1'b1; src_valid = 4'b1011;
        for (int k = 0; k < 15; k++) begin
            if (k == 5) sd[1] = 8'h5A;
            tick_show("auto_rot", seq_rot[k]);
        end

        // Manual advance with wrap from 3 to 0.
        auto_en = 1'b0; src_valid = 4'b1111;
        tick_show("manual_hold", 0);
        next_p = 1'b1;
        tick_show("manual_adv", 1);
        tick_show("manual_adv", 2);
        tick_show("manual_adv", 3);
        next_p = 1'b0;
        tick_show("manual_hold", 3);
        next_p = 1'b1;
        tick_show("manual_wrap", 0);
        next_p = 1'b0;

        // next coinciding with dwell expiry moves exactly one source.
        auto_en = 1'b1;
        tick_show("dwell_pre", 0);
        tick_show("dwell_pre", 0);
        tick_show("dwell_pre", 0);
        next_p = 1'b1;
        tick_show("next_and_expiry", 1);
        next_p = 1'b0; auto_en = 1'b0;
        tick_show("next_and_expiry_hold", 1);

        // Urgent override from source 2, return with a fresh dwell.
        next_p = 1'b1;
        tick_show("to_src2", 2);
        next_p = 1'b0;
        tick_show("to_src2", 2);
        urgent = 4'b1000; auto_en = 1'b1;
        tick_show("urgent_hold", 3);
        urgent = 4'b0000;
        tick_show("urgent_hold", 3);
        tick_show("urgent_hold", 3);
        for (int i = 0; i < 4; i++) tick_show("urgent_return_dwell", 2);
        tick_show("dwell_after_return", 3);

        // Saved source drops during urgent: advance from the saved index.
        auto_en = 1'b0;
        tick_show("hold3", 3);
        next_p = 1'b1;
        tick_show("to_src2b", 0);
        tick_show("to_src2b", 1);
        tick_show("to_src2b", 2);
        next_p = 1'b0;
        urgent = 4'b1000;
        tick_show("urgent2_hold", 3);
        urgent = 4'b0000; src_valid = 4'b1011;
        tick_show("urgent2_hold", 3);
        tick_show("urgent2_hold", 3);
        tick_show("urgent2_adv_saved", 3);
        tick_show("urgent2_adv_saved", 3);

        // Lowest urgent wins; a second pulse restarts the hold.
        src_valid = 4'b1111;
        urgent = 4'b0110;
        tick_show("urgent_lowest", 1);
        urgent = 4'b0000;
        tick_show("urgent_lowest", 1);
        urgent = 4'b0100;
        tick_show("urgent_restart", 2);
        urgent = 4'b0000;
        tick_show("urgent_restart", 2);
        tick_show("urgent_restart", 2);
        tick_show("urgent_restart_return", 3);

        // All sources drop -> blank; reset during urgent.
        next_p = 1'b1;
        tick_show("to_src1", 0);
        tick_show("to_src1", 1);
        next_p = 1'b0;
        src_valid = 4'b0000;
        tick_blank("all_drop", 1'b0);
        tick_blank("all_drop", 1'b0);
        src_valid = 4'b1111;
        tick_show("idle_lowest", 0);
        urgent = 4'b0010;
        tick_show("urgent_pre_rst", 1);
        urgent = 4'b0000;
        tick_show("urgent_pre_rst", 1);
        rst = 1'b1; urgent = 4'b0100;
        tick_blank("rst_in_urgent", 1'b1);
        rst = 1'b0; urgent = 4'b0000; src_valid = 4'b0000;
        tick_blank("after_rst", 1'b1);

        cyc();
        cyc();
        if (q.size() != 0) begin
            $display("FAIL leftover: %0d expectations unchecked, want 0", q.size());
            n_fail += q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
